// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with two-flop input synchronizer, mid-bit
//            sampling state machine and a small valid/ready receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLKS_PER_BIT = 216,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int DEPTH = 2 ** FIFO_DEPTH;

    localparam logic [CNT_W-1:0] c_term = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_half = CNT_W'(CLKS_PER_BIT / 2);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_start = 3'd1;
    localparam logic [2:0] c_data  = 3'd2;
    localparam logic [2:0] c_stop  = 3'd3;
    localparam logic [2:0] c_break = 3'd4;

    // ------------------------------------------------------------------------
    // Input synchronizer (idle-high line, so both flops reset to 1)
    // ------------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rxs;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_frame_error;
    logic             r_overrun;

    logic [2:0]       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_tick;
    logic             w_shift_en;
    logic             w_bit_clr;
    logic             w_push_req;
    logic             w_frame_err;

    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_bit_clr    = 1'b0;
        w_push_req   = 1'b0;
        w_frame_err  = 1'b0;
        w_tick       = (r_cnt == c_term);

        case (r_state)
            c_idle: begin
                if (!r_rxs) begin
                    w_state_next = c_start;
                end
            end
            c_start: begin
                // Re-check the line at mid start bit to reject short glitches
                if (r_cnt == c_half) begin
                    if (!r_rxs) begin
                        w_state_next = c_data;
                        w_bit_clr    = 1'b1;
                    end else begin
                        w_state_next = c_idle;
                    end
                end
            end
            c_data: begin
                if (w_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = c_stop;
                    end
                end
            end
            c_stop: begin
                if (w_tick) begin
                    if (r_rxs) begin
                        w_push_req   = 1'b1;
                        w_state_next = c_idle;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = c_break;
                    end
                end
            end
            c_break: begin
                // A held-low line reports once and then waits for idle
                if (r_rxs) begin
                    w_state_next = c_idle;
                end
            end
            default: begin
                w_state_next = c_idle;
            end
        endcase

        if ((w_state_next != r_state) || w_tick) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------------
    logic [7:0]          r_mem [DEPTH];
    logic [FIFO_DEPTH:0] r_wr_ptr;
    logic [FIFO_DEPTH:0] r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_DEPTH] != r_rd_ptr[FIFO_DEPTH]) &&
                     (r_wr_ptr[FIFO_DEPTH-1:0] == r_rd_ptr[FIFO_DEPTH-1:0]);
    assign w_pop   = !w_empty && data_ready;
    // A simultaneous pop frees the slot the new byte needs
    assign w_push  = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_idle;
            r_cnt         <= '0;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'h00;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_frame_error <= w_frame_err;
            r_overrun     <= w_push_req && !w_push;

            if (w_bit_clr) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_shift_en) begin
                r_shift <= {r_rxs, r_shift[7:1]};
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_DEPTH-1:0]] <= r_shift;
        end
    end

    assign data_out    = r_mem[r_rd_ptr[FIFO_DEPTH-1:0]];
    assign data_valid  = !w_empty;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;

endmodule

`default_nettype wire
